// File: rtl/addr_router.sv
// Request router: per-switch-instance request FIFOs feeding a single round-robin
// scheduler that drives one shared switch bus and waits for a per-instance ack.
module addr_router #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             addr_in,
  input  logic [W_WIDTH-1:0]     wr_data_in,
  input  logic                   wr_rd_op,
  input  logic [7:0]             op_id_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   rsp_valid,
  output logic [W_WIDTH-1:0]     rsp_rd_data,
  output logic [7:0]             rsp_id,
  output logic                   rsp_err,
  output logic [7:0]             drop_cnt,
  output logic [4:0]             sw_addr_in,
  output logic [W_WIDTH-1:0]     sw_w_data_in,
  output logic                   wr_rd_s_in,
  output logic [NUM_SW_INST-1:0] sel_en_in,
  input  logic [NUM_SW_INST-1:0] ack_out,
  input  logic [W_WIDTH-1:0]     sw_rd_data_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_SW_INST - 1);

  typedef struct packed {
    logic [4:0]         addr;
    logic               wr;
    logic [W_WIDTH-1:0] data;
    logic [7:0]         id;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [2:0] sel;
  logic       in_range;
  entry_t     in_entry;

  assign sel      = addr_in[7:5];
  assign in_range = ({1'b0, sel} < 4'(NUM_SW_INST));
  assign in_entry = '{addr: addr_in[4:0], wr: wr_rd_op, data: wr_data_in, id: op_id_in};

  entry_t                 mem_q    [NUM_SW_INST][FIFO_DEPTH];
  logic [PW:0]            wr_ptr_q [NUM_SW_INST];
  logic [PW:0]            rd_ptr_q [NUM_SW_INST];
  logic [NUM_SW_INST-1:0] full, empty, push, pop;

  state_t         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  entry_t         cur_q, cur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [7:0]     rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [7:0]     drop_q, drop_d;

  logic           found;
  logic [GW-1:0]  win, cand;
  entry_t         head;
  logic           ack_hit;

  // Full when the wrap bits differ but the index bits match.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]) &&
                 (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]);
    end
  end

  // Out-of-range selects never match an instance, so they see ready_out = 1.
  always_comb begin
    ready_out = 1'b1;
    push      = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (sel == 3'(i)) begin
        ready_out = !full[i];
        push[i]   = valid_in && !full[i];
      end
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    cand  = last_grant_q;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_SW_INST; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + GW'(1);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign head = mem_q[win][rd_ptr_q[win][PW-1:0]];

  always_comb begin
    pop = '0;
    if (state_q == IDLE && found) pop[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + (PW+1)'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + (PW+1)'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][PW-1:0]] <= in_entry;
    end
  end

  always_comb begin
    sel_en_in    = '0;
    sw_addr_in   = '0;
    sw_w_data_in = '0;
    wr_rd_s_in   = 1'b0;
    if (state_q == BUSY) begin
      for (int i = 0; i < NUM_SW_INST; i++) sel_en_in[i] = (grant_q == GW'(i));
      sw_addr_in   = cur_q.addr;
      sw_w_data_in = cur_q.data;
      wr_rd_s_in   = cur_q.wr;
    end
  end

  assign ack_hit = |(ack_out & sel_en_in);

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = win;
          last_grant_d = win;
          cur_d        = head;
          cnt_d        = CW'(1);
        end
      end
      BUSY: begin
        if (ack_hit) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_q.id;
          rsp_err_d   = 1'b0;
          rsp_data_d  = cur_q.wr ? '0 : sw_rd_data_out;
          state_d     = IDLE;
          cnt_d       = '0;
        end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_q.id;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (valid_in && !in_range && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      cur_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      drop_q       <= drop_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_err     = rsp_err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_addr_router.sv
// Scoreboard bench for addr_router: per-instance expected-response queues, a
// behavioural switch model with programmable ack delay, and grant-order logging.
module tb_addr_router;

  localparam int NUM = 5;
  localparam int W   = 8;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     addr_in;
  logic [W-1:0]   wr_data_in;
  logic           wr_rd_op;
  logic [7:0]     op_id_in;
  logic           valid_in;
  logic           ready_out;
  logic           rsp_valid;
  logic [W-1:0]   rsp_rd_data;
  logic [7:0]     rsp_id;
  logic           rsp_err;
  logic [7:0]     drop_cnt;
  logic [4:0]     sw_addr_in;
  logic [W-1:0]   sw_w_data_in;
  logic           wr_rd_s_in;
  logic [NUM-1:0] sel_en_in;
  logic [NUM-1:0] ack_out;
  logic [W-1:0]   sw_rd_data_out;

  always #5 clk = ~clk;

  addr_router #(.NUM_SW_INST(NUM), .W_WIDTH(W), .FIFO_DEPTH(4), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wr_data_in(wr_data_in),
    .wr_rd_op(wr_rd_op), .op_id_in(op_id_in), .valid_in(valid_in), .ready_out(ready_out),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .drop_cnt(drop_cnt), .sw_addr_in(sw_addr_in), .sw_w_data_in(sw_w_data_in),
    .wr_rd_s_in(wr_rd_s_in), .sel_en_in(sel_en_in), .ack_out(ack_out),
    .sw_rd_data_out(sw_rd_data_out)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] id;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q [NUM][$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_delay = 1;
  bit   ack_en = 1'b1;
  bit   noise_en = 1'b1;
  int   exp_drop = 0;
  int   busy_cnt = 0;
  int   cur_g = 0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_fn(input int g, input logic [4:0] a);
    logic [2:0] gs;
    gs = g[2:0];
    if (g == 1 && a == 5'd3) return 8'hC3;
    return {gs, a} ^ 8'h5A;
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int i = 0; i < NUM; i++) t += sb_q[i].size();
    return t;
  endfunction

  function automatic int exp_len();
    if (ack_en && ack_delay < TMO) return ack_delay;
    return TMO;
  endfunction

  // Monitor + switch model, all on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      ack_out  = '0;
    end else begin
      if (rsp_valid) begin
        if (sb_q[cur_g].size() == 0) begin
          check("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          mon_e = sb_q[cur_g].pop_front();
          check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          check("rsp_data", 32'(rsp_rd_data), 32'(mon_e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
      if (sel_en_in != '0) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          check("sel_onehot", 32'($countones(sel_en_in)), 32'(1));
          for (int i = 0; i < NUM; i++) if (sel_en_in[i]) cur_g = i;
          grant_log.push_back(cur_g);
        end
        if (sb_q[cur_g].size() == 0) begin
          check("grant_unexpected", 32'(1), 32'(0));
        end else begin
          check("sw_addr", 32'(sw_addr_in), 32'(sb_q[cur_g][0].addr));
          check("sw_wdata", 32'(sw_w_data_in), 32'(sb_q[cur_g][0].wdata));
          check("sw_wr", 32'(wr_rd_s_in), 32'(sb_q[cur_g][0].wr));
        end
      end else if (busy_cnt > 0) begin
        check("win_len", 32'(busy_cnt), 32'(exp_len()));
        busy_cnt = 0;
      end
      ack_out        = '0;
      sw_rd_data_out = 8'hEE;
      if (sel_en_in != '0 && ack_en && busy_cnt == ack_delay) begin
        ack_out        = sel_en_in;
        sw_rd_data_out = rd_fn(cur_g, sw_addr_in);
      end
      if (noise_en) ack_out = ack_out | (NUM'($urandom) & ~sel_en_in);
    end
  end

  task automatic send(input logic [7:0] a, input logic wr, input logic [7:0] d,
                      input logic [7:0] id, input bit exp_acc);
    int   s;
    exp_t e;
    s          = int'(a[7:5]);
    addr_in    = a;
    wr_rd_op   = wr;
    wr_data_in = d;
    op_id_in   = id;
    valid_in   = 1'b1;
    @(negedge clk);
    if (s >= NUM) begin
      check("oor_ready", 32'(ready_out), 32'(1));
      if (exp_drop < 255) exp_drop++;
    end else begin
      check("accept", 32'(ready_out), 32'(exp_acc));
      if (ready_out) begin
        e.addr  = a[4:0];
        e.wr    = wr;
        e.wdata = d;
        e.id    = id;
        e.err   = !ack_en;
        e.rdata = (wr || !ack_en) ? 8'h00 : rd_fn(s, a[4:0]);
        sb_q[s].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb_total() != 0 || sel_en_in != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb_total()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input int budget);
    int n = 0;
    while (sel_en_in == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sel_seen", 32'(sel_en_in != '0), 32'(1));
  endtask

  task automatic check_grants(input int n, input int g0, input int g1, input int g2);
    int exp_g[3];
    exp_g = '{g0, g1, g2};
    check("grant_cnt", 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check("grant_order", 32'(grant_log[i]), 32'(exp_g[i]));
    grant_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; addr_in = '0; wr_data_in = '0; wr_rd_op = 1'b0; op_id_in = '0;
    valid_in = 1'b0; ack_out = '0; sw_rd_data_out = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_data", 32'(rsp_rd_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_drop", 32'(drop_cnt), 32'(0));
    check("rst_sel_en", 32'(sel_en_in), 32'(0));
    check("rst_sw_addr", 32'(sw_addr_in), 32'(0));
    check("rst_ready", 32'(ready_out), 32'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read to sw1 reg 3, ack on the third busy cycle.
    ack_en = 1'b1; ack_delay = 3;
    send(8'h23, 1'b0, 8'h77, 8'h5A, 1'b1);
    wait_sel(10);
    check("t1_sel_en", 32'(sel_en_in), 32'(5'b00010));
    check("t1_sw_addr", 32'(sw_addr_in), 32'(3));
    wait_drain(50);
    check("t1_rsp_id", 32'(rsp_id), 32'(8'h5A));
    check("t1_rsp_data", 32'(rsp_rd_data), 32'(8'hC3));
    check("t1_rsp_err", 32'(rsp_err), 32'(0));
    check_grants(1, 1, 0, 0);

    // Requests to sw0, sw2, sw4 with immediate acks, then sw0 again.
    ack_delay = 1;
    send(8'h00, 1'b1, 8'h11, 8'h10, 1'b1);
    send(8'h40, 1'b0, 8'h22, 8'h11, 1'b1);
    send(8'h80, 1'b1, 8'h33, 8'h12, 1'b1);
    wait_drain(50);
    check_grants(3, 0, 2, 4);
    send(8'h05, 1'b0, 8'h44, 8'h13, 1'b1);
    wait_drain(50);
    check_grants(1, 0, 0, 0);

    // Round-robin rotation: sw0 and sw3 wait behind sw1; sw3 must win first.
    ack_delay = 6;
    send(8'h20, 1'b1, 8'h55, 8'h20, 1'b1);
    send(8'h01, 1'b0, 8'h66, 8'h21, 1'b1);
    send(8'h61, 1'b0, 8'h77, 8'h22, 1'b1);
    wait_drain(80);
    check_grants(3, 1, 3, 0);

    // Ack arriving on the timeout edge wins.
    ack_delay = TMO;
    send(8'h4A, 1'b0, 8'h88, 8'h30, 1'b1);
    wait_drain(60);
    check("t4_rsp_err", 32'(rsp_err), 32'(0));
    check("t4_rsp_data", 32'(rsp_rd_data), 32'(rd_fn(2, 5'd10)));
    check_grants(1, 2, 0, 0);

    // No acks: fill sw0, confirm back-pressure is per instance, then timeouts.
    ack_en = 1'b0;
    send(8'h00, 1'b1, 8'hA0, 8'h40, 1'b1);
    send(8'h01, 1'b1, 8'hA1, 8'h41, 1'b1);
    send(8'h02, 1'b0, 8'hA2, 8'h42, 1'b1);
    send(8'h03, 1'b1, 8'hA3, 8'h43, 1'b1);
    send(8'h04, 1'b1, 8'hA4, 8'h44, 1'b1);
    send(8'h06, 1'b1, 8'hA6, 8'h45, 1'b0);
    addr_in = 8'h40;
    @(negedge clk);
    check("t5_ready_sel2", 32'(ready_out), 32'(1));
    @(posedge clk); #1;
    wait_drain(150);
    check("t5_rsp_err", 32'(rsp_err), 32'(1));
    check("t5_rsp_data", 32'(rsp_rd_data), 32'(0));
    grant_log.delete();

    // Out-of-range requests are swallowed and counted with saturation.
    ack_en = 1'b1; ack_delay = 2;
    send(8'hE0, 1'b1, 8'h00, 8'h50, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_sel", 32'(sel_en_in), 32'(0));
    end
    @(posedge clk); #1;
    check("t6_drop_1", 32'(drop_cnt), 32'(1));
    for (int i = 0; i < 299; i++) begin
      send({3'(5 + $urandom_range(0, 2)), 5'($urandom)}, 1'($urandom), 8'($urandom), 8'(i), 1'b1);
      if (exp_drop >= 250) check("t6_drop", 32'(drop_cnt), 32'(exp_drop));
    end
    check("t6_drop_sat", 32'(drop_cnt), 32'(255));

    // Reset in the middle of a busy window abandons everything.
    ack_en = 1'b0;
    send(8'h60, 1'b0, 8'h01, 8'h60, 1'b1);
    send(8'h61, 1'b0, 8'h02, 8'h61, 1'b1);
    wait_sel(10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t7_sel_en", 32'(sel_en_in), 32'(0));
    check("t7_rsp_valid", 32'(rsp_valid), 32'(0));
    check("t7_sw_addr", 32'(sw_addr_in), 32'(0));
    check("t7_drop", 32'(drop_cnt), 32'(0));
    for (int i = 0; i < NUM; i++) sb_q[i].delete();
    exp_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    grant_log.delete();
    repeat (5) begin
      @(negedge clk);
      check("t7_idle_sel", 32'(sel_en_in), 32'(0));
      check("t7_no_rsp", 32'(rsp_valid), 32'(0));
    end
    @(posedge clk); #1;
    ack_en = 1'b1; ack_delay = 2;
    send(8'h62, 1'b0, 8'h03, 8'h62, 1'b1);
    wait_drain(40);
    check_grants(1, 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
